// File: rtl/fir_tap_vin_buffer_ctrl.sv
// fir_tap_vin_buffer_ctrl
// Packs 32-bit FIR tap samples eight at a time into 256-bit DDR words,
// queues them in a 256-deep first-word-fall-through line buffer and pushes
// each BURST_LEN-word line to DDR as one write burst.
module fir_tap_vin_buffer_ctrl #(
   parameter real TCQ           = 0.1,
   parameter int  ADDR_WIDTH    = 30,
   parameter int  DATA_WIDTH    = 32,
   parameter int  MEM_DATA_BITS = 256,
   parameter int  BURST_LEN     = 128
) (
   input  logic                     ddr_clk_i,
   input  logic                     ddr_rst_n_i,
   input  logic                     frame_start_i,
   input  logic                     tap_vld_i,
   input  logic [DATA_WIDTH-1:0]    tap_data_i,
   output logic                     line_done_o,
   output logic [15:0]              line_idx_o,
   output logic                     overflow_o,
   output logic                     wr_ddr_req_o,
   output logic [7:0]               wr_ddr_len_o,
   output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
   input  logic                     wr_ddr_data_req_i,
   output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
   input  logic                     wr_ddr_finish_i
);

   localparam int SLOTS  = MEM_DATA_BITS / DATA_WIDTH;
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int DEPTH  = 256;
   localparam int PTR_W  = 8;
   localparam int CNT_W  = 9;

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

   // TCQ is a simulation register delay in the original flow; registers here
   // are zero-delay, so the value is only sanity-checked at elaboration.
   generate
      if (TCQ < 0.0) begin : g_tcq_negative
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_REQ,
      S_WRITING,
      S_DONE
   } state_t;

   state_t state;

   logic [SLOT_W-1:0]               slot_cnt;
   logic [MEM_DATA_BITS-DATA_WIDTH-1:0] pack_sr;
   logic [MEM_DATA_BITS-1:0]        pack_word;
   logic                            last_slot;
   logic                            push_req;
   logic                            push;
   logic                            pop;
   logic                            full;
   logic                            empty;
   logic                            burst_live;

   logic [MEM_DATA_BITS-1:0]        mem [DEPTH];
   logic [PTR_W-1:0]                wr_ptr;
   logic [PTR_W-1:0]                rd_ptr;
   logic [CNT_W-1:0]                fifo_cnt;
   logic [MEM_DATA_BITS-1:0]        head;
   logic [MEM_DATA_BITS-1:0]        data_hold;

   logic [15:0]                     line_cnt;
   logic [7:0]                      beat_cnt;
   logic [29:0]                     line_addr;

   // Oldest sample ends up in the top lane because each new sample shifts in
   // at the bottom; the word is complete on the edge that takes the last slot.
   assign pack_word = {pack_sr, tap_data_i};
   assign last_slot = (slot_cnt == SLOT_W'(SLOTS - 1));
   assign push_req  = tap_vld_i && last_slot && !frame_start_i;
   assign full      = (fifo_cnt == FULL_CNT);
   assign empty     = (fifo_cnt == '0);
   assign push      = push_req && !full;

   // Pops are only honoured while a burst is open and has beats left.
   assign burst_live = ((state == S_REQ) || (state == S_WRITING)) &&
                       ({1'b0, beat_cnt} < BURST_CNT);
   assign pop        = burst_live && wr_ddr_data_req_i && !empty;

   assign head      = mem[rd_ptr];
   assign line_addr = {2'd2, 4'd0, 1'b0, line_cnt, 7'd0};

   // The controller sees the live head during a burst; otherwise the last
   // word it pulled stays on the bus.
   assign wr_ddr_data_o = (burst_live && !empty) ? head : data_hold;

   // Sample packer: slot counter and shift register, cleared by frame start.
   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         slot_cnt <= '0;
         pack_sr  <= '0;
      end else if (frame_start_i) begin
         slot_cnt <= '0;
         pack_sr  <= '0;
      end else if (tap_vld_i) begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
         pack_sr  <= pack_word[MEM_DATA_BITS-DATA_WIDTH-1:0];
      end
   end

   // Sticky overflow: a completed word met a full buffer and was dropped.
   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         overflow_o <= 1'b0;
      end else if (frame_start_i) begin
         overflow_o <= 1'b0;
      end else if (push_req && full) begin
         overflow_o <= 1'b1;
      end
   end

   // Line buffer storage; contents need no reset, pointers define validity.
   always_ff @(posedge ddr_clk_i) begin
      if (push) begin
         mem[wr_ptr] <= pack_word;
      end
   end

   // Line buffer pointers and occupancy; push and pop run independently.
   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Remember the last word handed to the controller.
   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         data_hold <= '0;
      end else if (pop) begin
         data_hold <= head;
      end
   end

   // Burst sequencer with registered DDR request and line-done outputs.
   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         state         <= S_IDLE;
         line_cnt      <= '0;
         beat_cnt      <= '0;
         wr_ddr_req_o  <= 1'b0;
         wr_ddr_len_o  <= '0;
         wr_ddr_addr_o <= '0;
         line_done_o   <= 1'b0;
         line_idx_o    <= '0;
      end else begin
         if (pop) beat_cnt <= beat_cnt + 8'd1;

         case (state)
            S_IDLE: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (fifo_cnt >= BURST_CNT) begin
                  state         <= S_REQ;
                  wr_ddr_req_o  <= 1'b1;
                  wr_ddr_len_o  <= 8'(BURST_LEN);
                  wr_ddr_addr_o <= ADDR_WIDTH'(line_addr);
               end
            end
            S_REQ: begin
               if (wr_ddr_finish_i) begin
                  state        <= S_DONE;
                  wr_ddr_req_o <= 1'b0;
                  line_done_o  <= 1'b1;
                  line_idx_o   <= line_cnt;
               end else if (wr_ddr_data_req_i) begin
                  state        <= S_WRITING;
                  wr_ddr_req_o <= 1'b0;
               end
            end
            S_WRITING: begin
               if (wr_ddr_finish_i) begin
                  state       <= S_DONE;
                  line_done_o <= 1'b1;
                  line_idx_o  <= line_cnt;
               end
            end
            S_DONE: begin
               state       <= S_WAIT;
               line_done_o <= 1'b0;
               beat_cnt    <= '0;
               line_cnt    <= line_cnt + 16'd1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         // Frame start restarts line numbering and wins over the DONE increment.
         if (frame_start_i) line_cnt <= '0;
      end
   end

endmodule

// File: doc/fir_tap_vin_buffer_ctrl.md
FIR_TAP_VIN_BUFFER_CTRL -- requirements
Module: fir_tap_vin_buffer_ctrl

Interface
REQ-001 The block SHALL have these parameters: TCQ, default 0.1, register delay; ADDR_WIDTH, default 30, DDR address width; DATA_WIDTH, default 32, sample width; MEM_DATA_BITS, default 256, DDR word width; BURST_LEN, default 128, DDR words per line.
REQ-002 Port ddr_clk_i, input, 1, the only clock; every register is on its rising edge.
REQ-003 Port ddr_rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 Port frame_start_i, input, 1, one-cycle pulse; clears the line counter and the packer.
REQ-005 Port tap_vld_i, input, 1, FIR tap sample strobe.
REQ-006 Port tap_data_i, input, DATA_WIDTH, FIR tap sample.
REQ-007 Port line_done_o, output, 1, one-cycle pulse after a line has been committed to DDR.
REQ-008 Port line_idx_o, output, 16, index of the committed line; valid while line_done_o is high.
REQ-009 Port overflow_o, output, 1, sticky flag set when a packed word was dropped.
REQ-010 Port wr_ddr_req_o, input side of DDR controller, output, 1, write burst request.
REQ-011 Port wr_ddr_len_o, output, 8, burst length.
REQ-012 Port wr_ddr_addr_o, output, ADDR_WIDTH, burst start address.
REQ-013 Port wr_ddr_data_req_i, input, 1, controller pulls one DDR word per high cycle.
REQ-014 Port wr_ddr_data_o, output, MEM_DATA_BITS, DDR write data.
REQ-015 Port wr_ddr_finish_i, input, 1, one-cycle pulse when the burst is complete.

Function
REQ-016 Packer: 8 samples form one 256-bit word; sample 0 goes to [255:224] and sample 7 to [31:0], which matches MSB-first wide-to-narrow readout downstream.
REQ-017 The packer SHALL write the word into the line buffer on the same edge that captures sample 7; the 3-bit slot counter wraps 7->0.
REQ-018 The line buffer is a first-word-fall-through FIFO with depth 256 x MEM_DATA_BITS and a 9-bit occupancy count.
REQ-019 If the buffer is full when a packed word arrives, the word SHALL be dropped, overflow_o SHALL set and hold until reset or frame_start_i, and the slot counter still wraps.
REQ-020 The state machine SHALL have five states: IDLE, WAIT, REQ, WRITING, DONE.
REQ-021 IDLE SHALL go to WAIT unconditionally on the next cycle after reset release.
REQ-022 WAIT SHALL go to REQ when occupancy >= BURST_LEN.
REQ-023 On entry to REQ: wr_ddr_req_o=1, wr_ddr_len_o=BURST_LEN, wr_ddr_addr_o={2'd2,4'd0,1'd0,line_cnt[15:0],7'd0}; address and length SHALL stay stable until DONE.
REQ-024 wr_ddr_req_o SHALL deassert on the cycle after the first wr_ddr_data_req_i and SHALL move to WRITING.
REQ-025 In REQ and WRITING, wr_ddr_data_o = buffer head word; each wr_ddr_data_req_i pops one word in the same cycle.
REQ-026 Beat counter: 8 bits, counts pops; wr_ddr_data_req_i beyond BURST_LEN beats or on an empty buffer SHALL NOT pop, and wr_ddr_data_o stays at the last value.
REQ-027 WRITING SHALL go to DONE on wr_ddr_finish_i; a finish in REQ also goes to DONE.
REQ-028 DONE lasts one cycle: line_done_o=1, line_idx_o=line_cnt, line_cnt increments mod 2^16 (0xFFFF->0), beat counter cleared, then go to WAIT.
REQ-029 Simultaneous buffer push and pop SHALL leave occupancy unchanged; push and pop are independent of state.
REQ-030 frame_start_i SHALL clear line_cnt, the slot counter, and overflow_o in any state; the buffer contents and any in-flight burst SHALL NOT be affected.
REQ-031 If frame_start_i and DONE coincide, line_cnt SHALL become 0 (clear wins) while line_idx_o still reports the old value.

Reset
REQ-032 With ddr_rst_n_i low, the block SHALL asynchronously hold: state IDLE, buffer empty, line_cnt=0, slot counter=0, beat counter=0, wr_ddr_req_o=0, wr_ddr_len_o=0, wr_ddr_addr_o=0, wr_ddr_data_o=0, line_done_o=0, line_idx_o=0, overflow_o=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no line_done_o; reset release SHALL be taken synchronously.

Verification
REQ-034 Frame start, then 1024 samples 0..1023: one request with addr 0x20000000 and len 128; first word popped = {0,1,...,7} MSB-first; line_done_o with line_idx_o=0.
REQ-035 2048 samples with continuous data_req: two bursts at addr 0x20000000 and then 0x20000080; line_idx_o = 0 then 1.
REQ-036 Hold data_req low and push 2056 samples: overflow_o rises on the 257th word; occupancy stays 256; after draining, burst data is intact.
REQ-037 Preload line_cnt to 0xFFFF via 65535 lines, or force it: the burst goes to line 0xFFFF, then the next address uses line 0.
REQ-038 Reset mid-WRITING after 50 beats: all outputs go to reset values immediately, with no line_done_o.
REQ-039 frame_start_i in the same cycle as DONE: line_idx_o=old value, and the next burst address uses line 0.
